core_mem_s: RTL and testbench

- Memory pipeline station. It consumes the exe/mem register outputs (L1D val/cop/size, address, write data, ALU result, rd, write-enable) and drives the L1D request/response interface.
- Handles load and store handshakes, byte-lane steering, load extension and misalignment detection.
- Stalls the upstream stages while an access is outstanding.
- Loads the mem/wb register and provides the M-stage forwarding value.

---
 rtl/core_mem_s_pkg.sv | 19 +
 rtl/core_mem_lane.sv | 47 ++++
 rtl/core_mem_s.sv | 186 ++++++++++++++++++
 tb/tb_core_mem_s.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_mem_s_pkg.sv
// rtl/core_mem_s_pkg.sv - shared size codes, command opcodes and FSM states for the M stage
package core_mem_s_pkg;

  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  localparam logic COP_RD = 1'b0;
  localparam logic COP_WR = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } mem_state_e;

endpackage

// File: rtl/core_mem_lane.sv
// rtl/core_mem_lane.sv - byte-lane steering, load extension and misalignment check
module core_mem_lane
  import core_mem_s_pkg::*;
(
  input  logic        cop_i,
  input  logic [2:0]  size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o,
  output logic        misalign_o
);

  logic [31:0] rshift;

  assign rshift = rdata_i >> {addr_lo_i, 3'b000};

  // Unsigned codes are load-only; a store carrying one is rejected as illegal.
  always_comb begin
    be_o       = 4'b0000;
    wdata_o    = wdata_i;
    rdata_o    = rshift;
    misalign_o = 1'b0;
    case (size_i)
      SZ_B, SZ_BU: begin
        be_o       = 4'b0001 << addr_lo_i;
        wdata_o    = {4{wdata_i[7:0]}};
        rdata_o    = (size_i == SZ_B) ? {{24{rshift[7]}}, rshift[7:0]} : {24'd0, rshift[7:0]};
        misalign_o = (size_i == SZ_BU) & cop_i;
      end
      SZ_H, SZ_HU: begin
        be_o       = 4'b0011 << addr_lo_i;
        wdata_o    = {2{wdata_i[15:0]}};
        rdata_o    = (size_i == SZ_H) ? {{16{rshift[15]}}, rshift[15:0]} : {16'd0, rshift[15:0]};
        misalign_o = addr_lo_i[0] | ((size_i == SZ_HU) & cop_i);
      end
      SZ_W: begin
        be_o       = 4'b1111;
        misalign_o = |addr_lo_i;
      end
      default: misalign_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/core_mem_s.sv
// rtl/core_mem_s.sv - memory pipeline station: L1D handshake FSM, stall and mem/wb register
module core_mem_s
  import core_mem_s_pkg::*;
#(
  parameter int TIMEOUT_CYC = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_val_inst_in,
  input  logic        mem_l1d_val_in,
  input  logic        mem_l1d_cop_in,
  input  logic [2:0]  mem_l1d_size_in,
  input  logic [31:0] mem_addr_in,
  input  logic [31:0] mem_wrt_data_in,
  input  logic [31:0] mem_alu_result_in,
  input  logic        mem_mux_alu_mem_in,
  input  logic        mem_we_reg_file_in,
  input  logic [4:0]  mem_rd_in,
  output logic        l1d_req_val,
  input  logic        l1d_req_ack,
  output logic        l1d_req_cop,
  output logic [31:0] l1d_req_addr,
  output logic [31:0] l1d_req_wdata,
  output logic [3:0]  l1d_req_be,
  input  logic        l1d_resp_val,
  input  logic [31:0] l1d_resp_data,
  output logic        mem_stall_out,
  output logic [31:0] mem_result_out,
  output logic        mem_misalign_out,
  output logic        mem_bus_err_out,
  output logic [31:0] mem_wb_data_out_reg,
  output logic        mem_we_reg_file_out_reg,
  output logic [4:0]  mem_rd_out_reg,
  output logic        mem_val_inst_out_reg
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  mem_state_e  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        req_cop_q, req_cop_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [31:0] req_wdata_q, req_wdata_d;
  logic [3:0]  req_be_q, req_be_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        wb_we_q, wb_we_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic        wb_val_q, wb_val_d;
  logic        misalign_q, misalign_d;
  logic        bus_err_q, bus_err_d;

  logic [3:0]  lane_be;
  logic [31:0] lane_wdata, lane_rdata;
  logic        lane_misalign, mem_op, access;
  logic        complete, load_done, timeout;

  core_mem_lane u_lane (
    .cop_i      (mem_l1d_cop_in),
    .size_i     (mem_l1d_size_in),
    .addr_lo_i  (mem_addr_in[1:0]),
    .wdata_i    (mem_wrt_data_in),
    .rdata_i    (l1d_resp_data),
    .be_o       (lane_be),
    .wdata_o    (lane_wdata),
    .rdata_o    (lane_rdata),
    .misalign_o (lane_misalign)
  );

  assign mem_op = mem_val_inst_in & mem_l1d_val_in;
  assign access = mem_op & ~lane_misalign;

  always_comb begin
    state_d     = state_q;
    cnt_d       = '0;
    req_cop_d   = req_cop_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    req_be_d    = req_be_q;
    misalign_d  = 1'b0;
    bus_err_d   = 1'b0;
    complete    = 1'b0;
    load_done   = 1'b0;
    timeout     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (access) begin
          state_d     = ST_REQ;
          req_cop_d   = mem_l1d_cop_in;
          req_addr_d  = {mem_addr_in[31:2], 2'b00};
          req_wdata_d = lane_wdata;
          req_be_d    = lane_be;
        end else begin
          complete   = 1'b1;
          misalign_d = mem_op & lane_misalign;
        end
      end
      ST_REQ: begin
        if (l1d_req_ack) begin
          if (req_cop_q == COP_WR) begin
            complete = 1'b1;
          end else if (l1d_resp_val) begin
            complete  = 1'b1;
            load_done = 1'b1;
          end else begin
            state_d = ST_RESP;
          end
        end
      end
      ST_RESP: begin
        if (l1d_resp_val) begin
          complete  = 1'b1;
          load_done = 1'b1;
        end else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
          complete  = 1'b1;
          timeout   = 1'b1;
          bus_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (complete && state_q != ST_IDLE) state_d = ST_IDLE;
  end

  // Upstream holds the exe/mem register while stalled, so its fields are valid at completion.
  always_comb begin
    wb_data_d = wb_data_q;
    wb_we_d   = wb_we_q;
    wb_rd_d   = wb_rd_q;
    wb_val_d  = 1'b0;
    if (complete) begin
      wb_val_d  = mem_val_inst_in;
      wb_rd_d   = mem_rd_in;
      wb_we_d   = mem_we_reg_file_in & ~(mem_op & lane_misalign) & ~timeout;
      wb_data_d = timeout ? 32'd0 :
                  mem_mux_alu_mem_in ? mem_alu_result_in :
                  load_done ? lane_rdata : 32'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      req_cop_q   <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      req_be_q    <= '0;
      wb_data_q   <= '0;
      wb_we_q     <= 1'b0;
      wb_rd_q     <= '0;
      wb_val_q    <= 1'b0;
      misalign_q  <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_cop_q   <= req_cop_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      req_be_q    <= req_be_d;
      wb_data_q   <= wb_data_d;
      wb_we_q     <= wb_we_d;
      wb_rd_q     <= wb_rd_d;
      wb_val_q    <= wb_val_d;
      misalign_q  <= misalign_d;
      bus_err_q   <= bus_err_d;
    end
  end

  assign l1d_req_val             = (state_q == ST_REQ);
  assign l1d_req_cop             = req_cop_q;
  assign l1d_req_addr            = req_addr_q;
  assign l1d_req_wdata           = req_wdata_q;
  assign l1d_req_be              = req_be_q;
  assign mem_stall_out           = ~complete;
  assign mem_result_out          = mem_alu_result_in;
  assign mem_misalign_out        = misalign_q;
  assign mem_bus_err_out         = bus_err_q;
  assign mem_wb_data_out_reg     = wb_data_q;
  assign mem_we_reg_file_out_reg = wb_we_q;
  assign mem_rd_out_reg          = wb_rd_q;
  assign mem_val_inst_out_reg    = wb_val_q;

endmodule

// File: tb/tb_core_mem_s.sv
// tb/tb_core_mem_s.sv - directed bench for core_mem_s with a transaction-level reference model
module tb_core_mem_s;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        val_i, lval_i, cop_i, mux_i, we_i;
  logic [2:0]  size_i;
  logic [31:0] addr_i, wd_i, alu_i;
  logic [4:0]  rd_i;
  logic        req_val, req_ack, req_cop, resp_val;
  logic [31:0] req_addr, req_wdata, resp_data;
  logic [3:0]  req_be;
  logic        stall, misal_o, bus_err_o, wb_we, wb_val;
  logic [31:0] fwd, wb_data;
  logic [4:0]  wb_rd;

  core_mem_s #(.TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst),
    .mem_val_inst_in(val_i), .mem_l1d_val_in(lval_i), .mem_l1d_cop_in(cop_i),
    .mem_l1d_size_in(size_i), .mem_addr_in(addr_i), .mem_wrt_data_in(wd_i),
    .mem_alu_result_in(alu_i), .mem_mux_alu_mem_in(mux_i),
    .mem_we_reg_file_in(we_i), .mem_rd_in(rd_i),
    .l1d_req_val(req_val), .l1d_req_ack(req_ack), .l1d_req_cop(req_cop),
    .l1d_req_addr(req_addr), .l1d_req_wdata(req_wdata), .l1d_req_be(req_be),
    .l1d_resp_val(resp_val), .l1d_resp_data(resp_data),
    .mem_stall_out(stall), .mem_result_out(fwd),
    .mem_misalign_out(misal_o), .mem_bus_err_out(bus_err_o),
    .mem_wb_data_out_reg(wb_data), .mem_we_reg_file_out_reg(wb_we),
    .mem_rd_out_reg(wb_rd), .mem_val_inst_out_reg(wb_val)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic val, lval, cop, mux, we, same;
    logic [2:0] size;
    logic [31:0] addr, wd, alu, rdata;
    logic [4:0] rd;
    int ack_dly, resp_dly;
  } inst_t;

  typedef struct {
    logic misal_p, bus_err, we, val, cop;
    logic [31:0] wb, req_addr, req_wd;
    logic [3:0] be;
    logic [4:0] rd;
    int stall;
  } exp_t;

  int n_tests = 0, n_fail = 0;
  bit cmp_en = 0, wb_pend = 0, prev_stall = 0;
  int stall_cnt = 0;
  exp_t cur_exp, wb_exp;
  int drv_st;
  bit drv_seen_req;
  logic [31:0] drv_addr, drv_wd;
  logic [3:0] drv_be;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic inst_t mk(input logic val, lval, cop, input logic [2:0] size,
                               input logic [31:0] addr, wd, alu, input logic mux, we,
                               input logic [4:0] rd, input logic [31:0] rdata,
                               input int ack_dly, resp_dly, input logic same);
    inst_t i;
    i.val = val; i.lval = lval; i.cop = cop; i.size = size; i.addr = addr; i.wd = wd;
    i.alu = alu; i.mux = mux; i.we = we; i.rd = rd; i.rdata = rdata;
    i.ack_dly = ack_dly; i.resp_dly = resp_dly; i.same = same;
    return i;
  endfunction

  // Reference: alignment as addr mod access-size, lane as a shifted mask, sign by OR-ing the high bits.
  function automatic exp_t model(input inst_t i);
    exp_t e;
    int a, nb;
    bit legal, misal, mop, acc, tmo, sgn;
    logic [31:0] mask, lane;
    a     = int'(i.addr % 4);
    legal = (i.size inside {3'd0, 3'd1, 3'd2}) || (!i.cop && (i.size inside {3'd4, 3'd5}));
    nb    = (i.size == 3'd2) ? 4 : (i.size == 3'd1 || i.size == 3'd5) ? 2 : 1;
    misal = !legal || (a % nb != 0);
    mop   = i.val && i.lval;
    acc   = mop && !misal;
    mask  = (nb == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * nb)) - 32'd1;
    lane  = (i.rdata >> (8 * a)) & mask;
    sgn   = (i.size == 3'd0 || i.size == 3'd1) && lane[8 * nb - 1];
    if (sgn) lane = lane | ~mask;
    tmo   = acc && !i.cop && !i.same && i.resp_dly == 0;
    e.cop      = i.cop;
    e.be       = 4'(((1 << nb) - 1) << a);
    e.req_addr = i.addr - 32'(a);
    e.req_wd   = (nb == 4) ? i.wd : (nb == 2) ? (i.wd & 32'hFFFF) * 32'h0001_0001
                                               : (i.wd & 32'hFF) * 32'h0101_0101;
    e.stall    = !acc ? 0 : (i.cop || i.same) ? 1 + i.ack_dly :
                 tmo ? 1 + i.ack_dly + TMO : 1 + i.ack_dly + i.resp_dly;
    e.we       = i.we && !(mop && misal) && !tmo;
    e.val      = i.val;
    e.rd       = i.rd;
    e.wb       = tmo ? 32'd0 : i.mux ? i.alu : (acc && !i.cop) ? lane : 32'd0;
    e.misal_p  = mop && misal;
    e.bus_err  = tmo;
    return e;
  endfunction

  always @(negedge clk) begin
    if (cmp_en) begin
      check("fwd", fwd, alu_i);
      if (wb_pend) begin
        check("wb_data", wb_data, wb_exp.wb);
        check("wb_we", 32'(wb_we), 32'(wb_exp.we));
        check("wb_rd", 32'(wb_rd), 32'(wb_exp.rd));
        check("wb_val", 32'(wb_val), 32'(wb_exp.val));
        check("misalign", 32'(misal_o), 32'(wb_exp.misal_p));
        check("bus_err", 32'(bus_err_o), 32'(wb_exp.bus_err));
        wb_pend = 0;
      end else begin
        check("misalign_idle", 32'(misal_o), 0);
        check("bus_err_idle", 32'(bus_err_o), 0);
        if (prev_stall) check("bubble", 32'(wb_val), 0);
      end
      if (req_val) begin
        check("req_addr", req_addr, cur_exp.req_addr);
        check("req_be", 32'(req_be), 32'(cur_exp.be));
        check("req_wdata", req_wdata, cur_exp.req_wd);
        check("req_cop", 32'(req_cop), 32'(cur_exp.cop));
      end
      if (stall) begin
        stall_cnt++;
        prev_stall = 1;
      end else begin
        check("stall_len", stall_cnt, cur_exp.stall);
        stall_cnt = 0;
        wb_exp = cur_exp;
        wb_pend = 1;
        prev_stall = 0;
      end
    end
  end

  // Called just after a rising edge; plays the L1D side until the instruction completes.
  task automatic do_inst(input inst_t i);
    int rc, ac;
    bit acked, done;
    cur_exp = model(i);
    cmp_en = 1;
    val_i = i.val; lval_i = i.lval; cop_i = i.cop; size_i = i.size; addr_i = i.addr;
    wd_i = i.wd; alu_i = i.alu; mux_i = i.mux; we_i = i.we; rd_i = i.rd;
    resp_data = i.rdata; req_ack = 0; resp_val = 0;
    rc = 0; ac = 0; acked = 0; done = 0; drv_st = 0; drv_seen_req = 0;
    for (int c = 0; c < 64 && !done; c++) begin
      if (acked) begin
        ac++;
        if (!i.cop && !i.same && i.resp_dly != 0 && ac == i.resp_dly) resp_val = 1;
      end else if (req_val) begin
        drv_seen_req = 1; drv_addr = req_addr; drv_be = req_be; drv_wd = req_wdata;
        if (rc == i.ack_dly) begin
          req_ack = 1; acked = 1;
          if (!i.cop && i.same) resp_val = 1;
        end
        rc++;
      end
      @(negedge clk);
      if (stall) drv_st++; else done = 1;
      @(posedge clk); #1;
      req_ack = 0; resp_val = 0;
    end
    if (!done) begin
      n_tests++; n_fail++;
      $display("FAIL complete_timeout: got stall still high expected completion");
    end
  endtask

  initial begin
    rst = 1; val_i = 0; lval_i = 0; cop_i = 0; size_i = 0; addr_i = 0; wd_i = 0;
    alu_i = 0; mux_i = 0; we_i = 0; rd_i = 0; req_ack = 0; resp_val = 0; resp_data = 0;
    repeat (2) @(posedge clk); #1;
    check("rst_req_val", 32'(req_val), 0);
    check("rst_req_be", 32'(req_be), 0);
    check("rst_wb_val", 32'(wb_val), 0);
    check("rst_wb_data", wb_data, 0);
    check("rst_stall", 32'(stall), 0);
    rst = 0;

    do_inst(mk(1, 1, 0, 3'd2, 32'h100, 0, 0, 0, 1, 5'd5, 32'h8000_00F0, 1, 2, 0));
    check("lw_data", wb_data, 32'h8000_00F0);
    check("lw_be", 32'(drv_be), 32'hF);
    check("lw_addr", drv_addr, 32'h100);
    check("lw_stall", drv_st, 4);
    do_inst(mk(1, 1, 0, 3'd0, 32'h103, 0, 0, 0, 1, 5'd6, 32'h80AA_BBCC, 0, 0, 1));
    check("lb_data", wb_data, 32'hFFFF_FF80);
    check("lb_stall", drv_st, 1);
    do_inst(mk(1, 1, 0, 3'd4, 32'h103, 0, 0, 0, 1, 5'd6, 32'h80AA_BBCC, 0, 0, 1));
    check("lbu_data", wb_data, 32'h0000_0080);
    do_inst(mk(1, 1, 1, 3'd1, 32'h202, 32'h0000_BEEF, 0, 0, 0, 5'd0, 0, 0, 0, 0));
    check("sh_be", 32'(drv_be), 32'hC);
    check("sh_wdata", drv_wd, 32'hBEEF_BEEF);
    check("sh_addr", drv_addr, 32'h200);
    check("sh_stall", drv_st, 1);
    do_inst(mk(1, 1, 0, 3'd2, 32'h101, 0, 32'h77, 0, 1, 5'd7, 0, 0, 0, 0));
    check("mis_pulse", 32'(misal_o), 1);
    check("mis_noreq", 32'(drv_seen_req), 0);
    check("mis_we", 32'(wb_we), 0);
    check("mis_val", 32'(wb_val), 1);
    do_inst(mk(1, 1, 0, 3'd3, 32'h100, 0, 32'h55, 1, 1, 5'd8, 0, 0, 0, 0));
    check("ill_noreq", 32'(drv_seen_req), 0);
    do_inst(mk(1, 0, 0, 3'd0, 32'h0, 0, 32'h1234, 1, 1, 5'd9, 0, 0, 0, 0));
    check("alu_data", wb_data, 32'h1234);
    do_inst(mk(1, 1, 0, 3'd1, 32'h102, 0, 0, 0, 1, 5'd10, 32'h8001_7FFF, 2, 1, 0));
    check("lh_data", wb_data, 32'hFFFF_8001);
    do_inst(mk(1, 1, 0, 3'd5, 32'h102, 0, 0, 0, 1, 5'd11, 32'h8001_7FFF, 0, 3, 0));
    check("lhu_data", wb_data, 32'h0000_8001);
    do_inst(mk(1, 1, 1, 3'd0, 32'h101, 32'h0000_005A, 0, 0, 0, 5'd0, 0, 3, 0, 0));
    check("sb_wdata", drv_wd, 32'h5A5A_5A5A);
    do_inst(mk(1, 1, 1, 3'd2, 32'h300, 32'hDEAD_BEEF, 32'h300, 1, 0, 5'd0, 0, 0, 0, 0));
    do_inst(mk(1, 1, 0, 3'd2, 32'h104, 0, 32'h99, 0, 1, 5'd12, 32'h1111_1111, 0, 0, 0));
    check("tmo_bus_err", 32'(bus_err_o), 1);
    check("tmo_data", wb_data, 0);
    check("tmo_we", 32'(wb_we), 0);
    check("tmo_stall", drv_st, 5);
    do_inst(mk(1, 1, 1, 3'd4, 32'h100, 32'h12, 0, 0, 1, 5'd13, 0, 0, 0, 0));
    do_inst(mk(0, 0, 0, 3'd0, 32'h0, 0, 0, 0, 0, 5'd0, 0, 0, 0, 0));
    @(negedge clk);
    cmp_en = 0;
    @(posedge clk); #1;

    // Reset while waiting in RESP, then a stale response that must be dropped.
    val_i = 1; lval_i = 1; cop_i = 0; size_i = 3'd2; addr_i = 32'h400; we_i = 1; rd_i = 5'd3;
    @(posedge clk); #1;
    check("rst_seq_req", 32'(req_val), 1);
    req_ack = 1;
    @(posedge clk); #1;
    req_ack = 0;
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    val_i = 0; lval_i = 0; size_i = 0; addr_i = 0; we_i = 0; rd_i = 0;
    resp_val = 1; resp_data = 32'hFFFF_FFFF;
    @(negedge clk);
    check("post_rst_stall", 32'(stall), 0);
    check("post_rst_req_val", 32'(req_val), 0);
    @(posedge clk); #1;
    resp_val = 0;
    check("stray_wb_data", wb_data, 0);
    check("stray_wb_we", 32'(wb_we), 0);
    check("stray_wb_val", 32'(wb_val), 0);
    check("stray_wb_rd", 32'(wb_rd), 0);
    check("stray_bus_err", 32'(bus_err_o), 0);
    check("stray_req_be", 32'(req_be), 0);
    check("stray_req_addr", req_addr, 0);
    check("stray_stall", 32'(stall), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
